// File: rtl/regfile_sb.sv
// Parametrised register file with write-through bypass, pending-write scoreboard
// and a post-reset sequencer that zeroes storage one entry per cycle.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              flush
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              run;
  logic              wr_en;
  logic              set_en;

  assign run    = (state == RUN);
  assign wr_en  = run && we && (waddr != '0);
  assign set_en = set_busy && (set_addr != '0);

  // Forwarding applies only to a live write aimed at the address being read.
  function automatic logic fwd_hit(input logic [ADDR_W-1:0] ra);
    return BYPASS && we && (waddr == ra);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    if (!run || ra == '0) val = '0;
    else if (fwd_hit(ra)) val = wdata;
    else val = mem[ra];
    return val;
  endfunction

  function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
    logic val;
    if (!run || ra == '0 || fwd_hit(ra)) val = 1'b0;
    else val = busy[ra];
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (&clr_cnt) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Storage carries no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[clr_cnt] <= '0;
    else if (wr_en) mem[waddr] <= wdata;
  end

  // Set is applied after clear so a re-issued destination stays pending.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en) busy_nxt[waddr] = 1'b0;
      if (set_en) busy_nxt[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else if (run) busy <= busy_nxt;
  end

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);
  assign busy1  = busy_port(raddr1);
  assign busy2  = busy_port(raddr2);

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write/dual-read CPU register file for the pipelined MIPS core.
- Adds configurable width and depth, optional write-through bypass, and a per-register scoreboard of pending-write bits used by decode for hazard detection.
- Adds a post-reset clear sequencer that zeroes storage one entry per cycle.
- Sits in the ID stage: reads go to decode, issue marks destinations pending, and WB writeback clears them.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- BYPASS, 1, 1 = a write in the current cycle is visible combinationally on the read ports; 0 = the value is visible the cycle after the write.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- init_done  output  1  high once the clear sequence has finished.
- we  input  1  writeback write enable.
- waddr  input  ADDR_W  writeback address.
- wdata  input  DATA_W  writeback data.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- rdata2  output  DATA_W  read port 2 data, combinational.
- busy1  output  1  pending-write status of raddr1.
- busy2  output  1  pending-write status of raddr2.
- set_busy  input  1  issue stage marks set_addr as pending.
- set_addr  input  ADDR_W  destination register being issued.
- flush  input  1  clears all pending bits (pipeline flush).

Behaviour:
- Reset (rst_n low at a posedge):
  - FSM goes to INIT, clear counter = 0, all busy bits = 0, init_done = 0.
  - Storage is not cleared by reset itself; the INIT state clears it.
- FSM states: INIT and RUN.
  - INIT: each cycle writes 0 to entry[counter], then counter increments.
  - When counter == DEPTH-1 has been written, go to RUN and set init_done = 1 on the next cycle. INIT therefore lasts exactly DEPTH cycles after reset deassertion.
  - RUN is terminal until the next reset.
  - Reset asserted mid-INIT restarts the sequence at counter 0.
- During INIT:
  - we, set_busy and flush are ignored.
  - rdata1, rdata2, busy1 and busy2 all read 0.
- Register 0 is hardwired:
  - It always reads 0.
  - Writes to it are dropped.
  - set_busy to it is dropped, so busy for address 0 is always 0.
- Write (RUN state): on a posedge with we = 1 and waddr != 0, entry[waddr] <= wdata.
- Read (combinational):
  - rdataN = 0 if raddrN == 0.
  - Otherwise, if BYPASS = 1 and we = 1 and waddr == raddrN, rdataN = wdata.
  - Otherwise rdataN = entry[raddrN].
- Scoreboard, per posedge in RUN, in priority order:
  - flush = 1: all busy bits cleared. A set_busy in the same cycle is also discarded, and flush wins over any write-clear.
  - Otherwise, we with waddr != 0 clears busy[waddr].
  - Then set_busy with set_addr != 0 sets busy[set_addr].
  - When set and clear hit the same address in the same cycle, the set wins (the newer producer is still pending).
- Busy outputs:
  - busyN = busy[raddrN] when raddrN != 0, otherwise 0.
  - If BYPASS = 1 and we = 1 and waddr == raddrN, busyN = 0, consistent with the forwarded data.
  - Busy outputs do not reflect set_busy in the same cycle.
- Width rules: addresses are used unsigned and wrap naturally within DEPTH; there is no out-of-range case.

Test Plan:
- Clear sequence, default parameters: hold rst_n = 0 for 2 cycles, then release. init_done stays 0 for exactly 32 cycles and rises on cycle 33. Any read during INIT returns 0 and busy reads 0. With we = 1 driven during INIT, the register still reads 0 afterwards.
- Write/read with BYPASS = 1: we = 1, waddr = 5, wdata = 0xDEADBEEF, raddr1 = 5. rdata1 = 0xDEADBEEF in the same cycle. With BYPASS = 0, the same stimulus gives the old value 0 in that cycle and 0xDEADBEEF the next cycle.
- Zero register: write 0x12345678 to address 0 and set_busy with set_addr = 0. rdata1 = 0 and busy1 = 0 for raddr1 = 0.
- Scoreboard:
  - Cycle 1: set_busy, set_addr = 7.
  - Cycle 2: busy1 = 1 for raddr1 = 7.
  - Cycle 3: we with waddr = 7 and set_busy with set_addr = 7 together. busy stays 1 afterwards (set wins); with BYPASS = 1, busy1 = 0 during that cycle.
  - Cycle 4: we with waddr = 7 alone. busy1 = 0 next cycle.
- Flush: set busy on registers 3, 4 and 9, then flush = 1 together with set_busy, set_addr = 10. All four busy bits read 0 next cycle.
- Mid-INIT reset: release reset, wait 10 cycles, assert rst_n = 0 for 1 cycle, release. init_done rises 33 cycles after the second release. Reset asserted in RUN clears busy bits at the next posedge.
